// File: rtl/sprite_layer_compositor.sv
// N-layer sprite compositor: per-layer hit test and ROM addressing, ROM latency alignment, priority pick.
// Optional sticky overlap detection is compiled in with SPRITE_COMPOSITOR_COLLIDE_EN.
module sprite_layer_compositor #(
  parameter int NUM_LAYERS = 8,
  parameter int X_W        = 10,
  parameter int Y_W        = 9,
  parameter int ADDR_W     = 14,
  parameter int PIX_W      = 12,
  parameter int ROM_LAT    = 1,
  localparam int HIT_W     = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pix_valid_in,
  input  logic [X_W-1:0]               x_in,
  input  logic [Y_W-1:0]               y_in,
  input  logic [NUM_LAYERS-1:0]        layer_en,
  input  logic [NUM_LAYERS*X_W-1:0]    layer_x,
  input  logic [NUM_LAYERS*Y_W-1:0]    layer_y,
  input  logic [NUM_LAYERS*X_W-1:0]    layer_w,
  input  logic [NUM_LAYERS*Y_W-1:0]    layer_h,
  input  logic [NUM_LAYERS*PIX_W-1:0]  layer_key,
  output logic [NUM_LAYERS*ADDR_W-1:0] rom_addr,
  input  logic [NUM_LAYERS*PIX_W-1:0]  rom_data,
  input  logic [PIX_W-1:0]             bg_pix,
  input  logic                         clear_collide,
  output logic [PIX_W-1:0]             pix_out,
  output logic                         pix_valid_out,
  output logic [HIT_W-1:0]             hit_layer,
  output logic                         hit_valid,
  output logic [NUM_LAYERS-1:0]        collide_mask
);

  localparam int P_W = X_W + Y_W;

  logic [NUM_LAYERS-1:0]        in_c;
  logic [NUM_LAYERS*ADDR_W-1:0] addr_c;

  for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_layer
    logic [X_W-1:0] lx, lw;
    logic [Y_W-1:0] ly, lh;
    logic [X_W:0]   x_end;
    logic [Y_W:0]   y_end;
    logic [P_W-1:0] dx, dy, wx;

    assign lx = layer_x[i*X_W +: X_W];
    assign lw = layer_w[i*X_W +: X_W];
    assign ly = layer_y[i*Y_W +: Y_W];
    assign lh = layer_h[i*Y_W +: Y_W];

    // One extra bit on the far edge so a sprite hugging the screen edge cannot wrap to 0.
    assign x_end = {1'b0, lx} + {1'b0, lw};
    assign y_end = {1'b0, ly} + {1'b0, lh};

    assign in_c[i] = pix_valid_in && layer_en[i] &&
                     (x_in >= lx) && ({1'b0, x_in} < x_end) &&
                     (y_in >= ly) && ({1'b0, y_in} < y_end);

    assign dx = P_W'(x_in - lx);
    assign dy = P_W'(y_in - ly);
    assign wx = P_W'(lw);
    assign addr_c[i*ADDR_W +: ADDR_W] = in_c[i] ? ADDR_W'(dy * wx + dx) : '0;
  end

  // Index 0 is the stage A register; indices 1..ROM_LAT shadow the ROM read.
  logic [ROM_LAT:0]             d_valid;
  logic [NUM_LAYERS-1:0]        d_in  [ROM_LAT+1];
  logic [NUM_LAYERS*PIX_W-1:0]  d_key [ROM_LAT+1];

  // NOTE: state uses non-blocking assignments so every stage samples pre-edge values of the one before it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_valid  <= '0;
      rom_addr <= '0;
      for (int k = 0; k <= ROM_LAT; k++) d_in[k] <= '0;
    end else begin
      d_valid[0] <= pix_valid_in;
      d_in[0]    <= in_c;
      rom_addr   <= addr_c;
      for (int k = 1; k <= ROM_LAT; k++) begin
        d_valid[k] <= d_valid[k-1];
        d_in[k]    <= d_in[k-1];
      end
    end
  end

  // NOTE: the key shadow is pure datapath qualified by d_in, so it carries no reset.
  always_ff @(posedge clk) begin
    d_key[0] <= layer_key;
    for (int k = 1; k <= ROM_LAT; k++) d_key[k] <= d_key[k-1];
  end

  logic [NUM_LAYERS-1:0] opaque;
  logic [HIT_W-1:0]      win_idx;
  logic                  win_any;
  logic [PIX_W-1:0]      win_pix;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    opaque  = '0;
    win_idx = '0;
    win_any = 1'b0;
    win_pix = bg_pix;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      opaque[i] = d_in[ROM_LAT][i] &&
                  (rom_data[i*PIX_W +: PIX_W] != d_key[ROM_LAT][i*PIX_W +: PIX_W]);
    end
    // Ascending scan: the last opaque layer seen is the topmost one.
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (opaque[i]) begin
        win_idx = HIT_W'(i);
        win_any = 1'b1;
        win_pix = rom_data[i*PIX_W +: PIX_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_out       <= '0;
      pix_valid_out <= 1'b0;
      hit_layer     <= '0;
      hit_valid     <= 1'b0;
    end else begin
      pix_valid_out <= d_valid[ROM_LAT];
      if (d_valid[ROM_LAT]) begin
        pix_out   <= win_pix;
        hit_layer <= win_idx;
        hit_valid <= win_any;
      end
    end
  end

`ifdef SPRITE_COMPOSITOR_COLLIDE_EN
  logic [NUM_LAYERS-1:0] collide_set;

  always_comb begin
    collide_set = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      collide_set[i] = opaque[i] && |(opaque & ~(NUM_LAYERS'(1) << i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                collide_mask <= '0;
    else if (clear_collide) collide_mask <= '0;
    else                    collide_mask <= collide_mask | collide_set;
  end
`else
  logic unused_clear_collide;
  assign unused_clear_collide = clear_collide;
  assign collide_mask         = '0;
`endif

endmodule

// File: tb/tb_sprite_layer_compositor.sv
// Directed bench for sprite_layer_compositor (ROM_LAT=1): reset, addressing, keys, priority, edges, overlap.
module tb_sprite_layer_compositor;
  localparam int NL = 8, XW = 10, YW = 9, AW = 14, PW = 12;

  logic            clk = 1'b0;
  logic            rst;
  logic            pix_valid_in;
  logic [XW-1:0]   x_in;
  logic [YW-1:0]   y_in;
  logic [NL-1:0]   layer_en;
  logic [NL*XW-1:0] layer_x, layer_w;
  logic [NL*YW-1:0] layer_y, layer_h;
  logic [NL*PW-1:0] layer_key, rom_data;
  logic [NL*AW-1:0] rom_addr;
  logic [PW-1:0]   bg_pix;
  logic            clear_collide;
  logic [PW-1:0]   pix_out;
  logic            pix_valid_out;
  logic [2:0]      hit_layer;
  logic            hit_valid;
  logic [NL-1:0]   collide_mask;

  sprite_layer_compositor #(
    .NUM_LAYERS(NL), .X_W(XW), .Y_W(YW), .ADDR_W(AW), .PIX_W(PW), .ROM_LAT(1)
  ) dut (
    .clk(clk), .rst(rst), .pix_valid_in(pix_valid_in), .x_in(x_in), .y_in(y_in),
    .layer_en(layer_en), .layer_x(layer_x), .layer_y(layer_y), .layer_w(layer_w),
    .layer_h(layer_h), .layer_key(layer_key), .rom_addr(rom_addr), .rom_data(rom_data),
    .bg_pix(bg_pix), .clear_collide(clear_collide), .pix_out(pix_out),
    .pix_valid_out(pix_valid_out), .hit_layer(hit_layer), .hit_valid(hit_valid),
    .collide_mask(collide_mask)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  logic [NL*AW-1:0] addr_snap;
  int lat;
  logic seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_layer(input int i, input logic en, input logic [XW-1:0] x, input logic [YW-1:0] y,
                           input logic [XW-1:0] w, input logic [YW-1:0] h,
                           input logic [PW-1:0] key, input logic [PW-1:0] rom);
    layer_en[i]           = en;
    layer_x[i*XW +: XW]   = x;
    layer_y[i*YW +: YW]   = y;
    layer_w[i*XW +: XW]   = w;
    layer_h[i*YW +: YW]   = h;
    layer_key[i*PW +: PW] = key;
    rom_data[i*PW +: PW]  = rom;
  endtask

  // Presents one pixel for one clock; rom_addr is snapshotted right after stage A captures it.
  task automatic send_pixel(input logic [XW-1:0] x, input logic [YW-1:0] y);
    @(negedge clk);
    pix_valid_in = 1'b1;
    x_in = x;
    y_in = y;
    @(negedge clk);
    pix_valid_in = 1'b0;
    addr_snap = rom_addr;
  endtask

  // Counts capture edges until pix_valid_out, starting at 1 for the edge that took the pixel.
  task automatic wait_out(input string tag);
    logic got;
    got = 1'b0;
    lat = 1;
    for (int k = 0; k < 8 && !got; k++) begin
      @(posedge clk);
      #1;
      lat++;
      if (pix_valid_out) got = 1'b1;
    end
    if (!got) lat = -1;
    check(tag, lat, 3);
  endtask

  task automatic run(input string tag, input logic [XW-1:0] x, input logic [YW-1:0] y);
    send_pixel(x, y);
    wait_out(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    pix_valid_in = 1'b0; x_in = '0; y_in = '0;
    layer_en = '0; layer_x = '0; layer_y = '0; layer_w = '0; layer_h = '0;
    layer_key = '0; rom_data = '0; bg_pix = '0; clear_collide = 1'b0;

    // Reset state
    #12;
    check("rst_pix_out", pix_out, 0);
    check("rst_valid", pix_valid_out, 0);
    check("rst_hit_valid", hit_valid, 0);
    check("rst_hit_layer", hit_layer, 0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_collide", collide_mask, 0);
    @(negedge clk);
    rst = 1'b0;

    // Continuous stream, then an asynchronous reset in the middle of it
    set_layer(0, 1'b1, 100, 50, 47, 41, 12'h428, 12'hFFF);
    bg_pix = 12'h0F0;
    @(negedge clk);
    pix_valid_in = 1'b1; x_in = 146; y_in = 90;
    repeat (4) @(negedge clk);
    check("stream_valid", pix_valid_out, 1);
    check("stream_pix", pix_out, 12'hFFF);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_valid", pix_valid_out, 0);
    check("midrst_pix", pix_out, 0);
    check("midrst_hit_valid", hit_valid, 0);
    check("midrst_rom_addr", rom_addr, 0);
    pix_valid_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      seen = seen | pix_valid_out;
    end
    check("no_partial_out", seen, 0);

    // Single-layer address, opaque pixel, latency, bubble hold
    run("lat_in_box", 146, 90);
    check("addr0_in", addr_snap[0 +: AW], 1926);
    check("in_pix", pix_out, 12'hFFF);
    check("in_hit_layer", hit_layer, 0);
    check("in_hit_valid", hit_valid, 1);
    @(posedge clk);
    #1;
    check("bubble_valid", pix_valid_out, 0);
    check("bubble_hold", pix_out, 12'hFFF);
    run("lat_out_box", 147, 90);
    check("addr0_out", addr_snap[0 +: AW], 0);
    check("out_hit_valid", hit_valid, 0);
    check("out_bg", pix_out, 12'h0F0);

    // Transparency key on the only hit layer
    rom_data[0 +: PW] = 12'h428;
    run("lat_key", 146, 90);
    check("key_pix", pix_out, 12'h0F0);
    check("key_hit_valid", hit_valid, 0);
    check("key_hit_layer", hit_layer, 0);

    // Priority between overlapping layers
    layer_en[0] = 1'b0;
    set_layer(2, 1'b1, 0, 0, 64, 64, 12'h000, 12'h111);
    set_layer(5, 1'b1, 0, 0, 64, 64, 12'h000, 12'h555);
    run("lat_prio", 10, 10);
    check("prio_pix", pix_out, 12'h555);
    check("prio_layer", hit_layer, 5);
    check("prio_addr5", addr_snap[5*AW +: AW], 650);
    layer_en[5] = 1'b0;
    run("lat_prio_off", 10, 10);
    check("prio_off_pix", pix_out, 12'h111);
    check("prio_off_layer", hit_layer, 2);

    // Right-edge no-wrap; layer changes after capture do not affect the in-flight pixel
    layer_en = '0;
    set_layer(7, 1'b1, 1020, 0, 10, 10, 12'h000, 12'h777);
    set_layer(6, 1'b1, 0, 0, 0, 10, 12'h000, 12'h666);
    send_pixel(1023, 5);
    layer_en = '0;
    wait_out("lat_edge");
    check("edge_hit_valid", hit_valid, 1);
    check("edge_layer", hit_layer, 7);
    check("edge_pix", pix_out, 12'h777);
    check("edge_addr7", addr_snap[7*AW +: AW], 53);
    layer_en[7] = 1'b1;
    layer_en[6] = 1'b1;
    run("lat_wrap", 3, 5);
    check("wrap_hit_valid", hit_valid, 0);
    check("wrap_pix", pix_out, 12'h0F0);
    run("lat_w0", 0, 5);
    check("w0_hit_valid", hit_valid, 0);
    check("w0_addr6", addr_snap[6*AW +: AW], 0);

    // Back-to-back pixels, one per clock
    @(negedge clk);
    pix_valid_in = 1'b1; x_in = 1023; y_in = 5;
    @(negedge clk);
    x_in = 3;
    @(negedge clk);
    pix_valid_in = 1'b0;
    @(posedge clk);
    #1;
    check("b2b_valid0", pix_valid_out, 1);
    check("b2b_hit0", hit_valid, 1);
    @(posedge clk);
    #1;
    check("b2b_valid1", pix_valid_out, 1);
    check("b2b_hit1", hit_valid, 0);

    // Overlap of layers 1 and 3
    layer_en = '0;
    set_layer(1, 1'b1, 0, 0, 64, 64, 12'h000, 12'h101);
    set_layer(3, 1'b1, 0, 0, 64, 64, 12'h000, 12'h303);
    run("lat_coll", 1, 1);
    check("coll_pix", pix_out, 12'h303);
    check("coll_layer", hit_layer, 3);
`ifdef SPRITE_COMPOSITOR_COLLIDE_EN
    check("coll_mask", collide_mask, 8'b0000_1010);
`else
    check("coll_mask_off", collide_mask, 0);
`endif
    layer_en[1] = 1'b0;
    run("lat_sticky", 1, 1);
`ifdef SPRITE_COMPOSITOR_COLLIDE_EN
    check("coll_sticky", collide_mask, 8'b0000_1010);
`else
    check("coll_sticky_off", collide_mask, 0);
`endif
    layer_en[1] = 1'b1;
    send_pixel(1, 1);
    @(negedge clk);
    clear_collide = 1'b1;
    @(negedge clk);
    clear_collide = 1'b0;
    check("clear_valid", pix_valid_out, 1);
    check("clear_wins", collide_mask, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/sprite_layer_compositor.md
Name: sprite_layer_compositor

Overview:
Pipelined N-layer sprite compositor between the VGA scan counter (vgac) and the colour output register. For each scan coordinate it does three things:
- Generates one image-ROM address per layer.
- Aligns the ROM read latency with the rest of the pipeline.
- Picks the topmost opaque layer pixel, using a per-layer transparency key, or falls back to the background pixel.

It replaces hand-unrolled per-sprite address and priority logic in the game top level.

Parameters:
NUM_LAYERS, 8, number of sprite layers; layer NUM_LAYERS-1 is topmost.
X_W, 10, width of x coordinate, layer x and layer width.
Y_W, 9, width of y coordinate, layer y and layer height.
ADDR_W, 14, per-layer ROM address width.
PIX_W, 12, pixel width (RGB444).
ROM_LAT, 1, ROM read latency in clocks (1 or 2).

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
pix_valid_in  in  1  scan coordinate valid
x_in  in  X_W  scan column
y_in  in  Y_W  scan row
layer_en  in  NUM_LAYERS  per-layer enable
layer_x  in  NUM_LAYERS*X_W  packed top-left x
layer_y  in  NUM_LAYERS*Y_W  packed top-left y
layer_w  in  NUM_LAYERS*X_W  packed width in pixels
layer_h  in  NUM_LAYERS*Y_W  packed height in pixels
layer_key  in  NUM_LAYERS*PIX_W  packed transparent colour
rom_addr  out  NUM_LAYERS*ADDR_W  packed ROM addresses
rom_data  in  NUM_LAYERS*PIX_W  packed ROM read data, valid ROM_LAT clocks after rom_addr
bg_pix  in  PIX_W  background pixel, presented aligned with rom_data
clear_collide  in  1  clears collide_mask (used only with the optional feature)
pix_out  out  PIX_W  composited pixel
pix_valid_out  out  1  pix_out valid strobe
hit_layer  out  clog2(NUM_LAYERS)  index of the winning layer
hit_valid  out  1  a layer (not background) won
collide_mask  out  NUM_LAYERS  sticky overlap flags (optional feature)

Behaviour:
- Reset (async, rst=1) forces these to 0: pix_out, pix_valid_out, hit_layer, hit_valid, rom_addr, collide_mask, and all pipeline valid and hit flags. Pipeline resumes on the first clk edge after rst falls.
- Stage A (1 clk): register the coordinate together with the layer snapshot. Layer inputs that change afterwards do not affect in-flight pixels.
- Hit test per layer:
  - in_i = layer_en[i] && x>=lx && x<lx+w && y>=ly && y<ly+h.
  - Sums are computed at X_W+1 / Y_W+1 bits, so an edge near the maximum does not wrap.
  - w=0 or h=0 means never hit.
- Address: rom_addr_i = (y-ly)*w + (x-lx), truncated to ADDR_W, when in_i=1; otherwise 0. It is registered at the end of stage A.
- Delay stages (ROM_LAT clks): carry valid, in_i and key_i alongside the ROM read.
- Stage C (1 clk):
  - opaque_i = in_i && (rom_data_i != key_i).
  - Winner = highest i with opaque_i. pix_out = rom_data of the winner, hit_layer = i, hit_valid = 1.
  - If no layer is opaque: pix_out = bg_pix, hit_layer = 0, hit_valid = 0.
- Latency: pix_valid_out rises exactly ROM_LAT+2 clks after pix_valid_in. Full throughput is one pixel per clk, with no stalls.
- Bubbles: when pix_valid_in=0, the bubble propagates. pix_out, hit_layer and hit_valid hold their last values, and pix_valid_out=0 for that slot.
- Equal keys: a pixel equal to the key is transparent even when it is the only hit layer, so the background shows through.
- Simultaneous hits: only the priority order matters; lower layers are discarded.
- A reset in mid-frame discards all in-flight pixels; no partial output appears.

Optional Feature:
Macro: SPRITE_COMPOSITOR_COLLIDE_EN.
- Defined:
  - In stage C, for each i, if opaque_i and any other opaque_j (j!=i), set collide_mask[i]=1. The flag is sticky.
  - clear_collide=1 clears the mask that clk, and clear wins over a same-cycle set.
  - This is used for the player/monster damage and freeze detection.
- Undefined: collide_mask is tied to 0, clear_collide is ignored, and no compare logic is generated.

Test Plan:
1. Reset with rst pulsed mid-stream, ROM_LAT=1 → all outputs 0 immediately. First pix_valid_out appears 3 clks after the first post-reset pix_valid_in.
2. Single-layer address: layer0 at x=100, y=50, w=47, h=41; scan (146,90) → rom_addr0 = 40*47+46 = 1926. Scan (147,90) → rom_addr0 = 0 and hit_valid=0.
3. Transparency: layer0 key=12'h428, rom_data0=12'h428 inside the box, bg_pix=12'h0F0 → pix_out=12'h0F0, hit_valid=0. With rom_data0=12'hFFF → pix_out=12'hFFF, hit_layer=0.
4. Priority: layers 2 and 5 both opaque at a pixel (12'h111 and 12'h555) → pix_out=12'h555, hit_layer=5. With layer_en[5]=0 → pix_out=12'h111, hit_layer=2.
5. Edge/no-wrap: layer x=1020, w=10, X_W=10; scan x=1023 → hit. Scan x=3 → no hit. Layer with w=0 → never hit.
6. With SPRITE_COMPOSITOR_COLLIDE_EN: layers 1 and 3 opaque on the same pixel → collide_mask=8'b0000_1010 and stays set. clear_collide plus a same-cycle overlap → 0 the next clk.
